// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and the
// default stability window.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // 10 ms at 100 MHz
  localparam int unsigned CNT_MAX_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, resets to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             sync_2ff_port_clk,
  input  logic             sync_2ff_port_rst,
  input  logic [WIDTH-1:0] sync_2ff_port_d,
  output logic [WIDTH-1:0] sync_2ff_oport_q
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Two back-to-back flops give the first stage a cycle to resolve metastability.
  always_ff @(posedge sync_2ff_port_clk) begin
    if (sync_2ff_port_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sync_2ff_port_d;
      sync2 <= sync1;
    end
  end

  assign sync_2ff_oport_q = sync2;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronises the raw input, requires CNT_MAX stable
// cycles before committing a new level, and pulses once per accepted press.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE_LOW  | committed level 0, waiting for the input to go high
// WAIT_HIGH | input high, counting stable cycles before committing 1
// IDLE_HIGH | committed level 1, waiting for the input to go low
// WAIT_LOW  | input low, counting stable cycles before committing 0
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter  int unsigned CNT_MAX = CNT_MAX_DEFAULT,
  localparam int unsigned CNT_W   = $clog2(CNT_MAX)
) (
  input  logic btn_debounce_port_clk,
  input  logic btn_debounce_port_rst,
  input  logic btn_debounce_port_btn,
  output logic btn_debounce_oport_level,
  output logic btn_debounce_oport_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             btn_s;
  db_state_t        state_q;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_q;
  logic             level_nxt;
  logic             pulse_q;
  logic             pulse_nxt;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .sync_2ff_port_clk (btn_debounce_port_clk),
    .sync_2ff_port_rst (btn_debounce_port_rst),
    .sync_2ff_port_d   (btn_debounce_port_btn),
    .sync_2ff_oport_q  (btn_s)
  );

  // State, counter and output registers; reset abandons any pending change.
  always_ff @(posedge btn_debounce_port_clk) begin
    if (btn_debounce_port_rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      level_q <= level_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  // Next-state logic: any disagreeing sample during a wait aborts the window,
  // and the counter saturates at CNT_LAST where the commit happens.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    level_nxt = level_q;
    pulse_nxt = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (btn_s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!btn_s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign btn_debounce_oport_level = level_q;
  assign btn_debounce_oport_pulse = pulse_q;

endmodule
